// File: rtl/reg_rename_file_pkg.sv
// rtl/reg_rename_file_pkg.sv - shared widths and id conventions for the rename register file
package reg_rename_file_pkg;

  // Width of ROB indices and rename tags
  localparam int ROB_WIDTH_BIT = 5;
  // Register index width (32 architectural registers)
  localparam int REG_NUM_BIT = 5;
  // x0 is hardwired to zero and is never renamed
  localparam int REG_X0 = 0;
  // A register id of 0 on a rename or commit port means "no operation"
  localparam int NOP_ID = 0;

endpackage

// File: rtl/reg_rename_file_if.sv
// rtl/reg_rename_file_if.sv - ROB commit/rename, decoder operand and ROB query signal bundle
interface reg_rename_file_if #(
  parameter int ROB_SIZE_BIT = reg_rename_file_pkg::ROB_WIDTH_BIT,
  parameter int REG_NUM_BIT  = reg_rename_file_pkg::REG_NUM_BIT
);
  logic                    rdy_in;
  logic                    clear_flag;
  logic [REG_NUM_BIT-1:0]  new_reg_id;
  logic [ROB_SIZE_BIT-1:0] new_ROB_id;
  logic [REG_NUM_BIT-1:0]  write_reg_id;
  logic [31:0]             write_val;
  logic [ROB_SIZE_BIT-1:0] write_ROB_id;
  logic [REG_NUM_BIT-1:0]  rs1_reg;
  logic [REG_NUM_BIT-1:0]  rs2_reg;
  logic                    rs1_ready;
  logic [31:0]             rs1_val;
  logic [ROB_SIZE_BIT-1:0] rs1_tag;
  logic                    rs2_ready;
  logic [31:0]             rs2_val;
  logic [ROB_SIZE_BIT-1:0] rs2_tag;
  logic [ROB_SIZE_BIT-1:0] rob_q1_id;
  logic                    rob_q1_ready;
  logic [31:0]             rob_q1_val;
  logic [ROB_SIZE_BIT-1:0] rob_q2_id;
  logic                    rob_q2_ready;
  logic [31:0]             rob_q2_val;

  modport slave (
    input  rdy_in, clear_flag, new_reg_id, new_ROB_id, write_reg_id, write_val, write_ROB_id,
    input  rs1_reg, rs2_reg, rob_q1_ready, rob_q1_val, rob_q2_ready, rob_q2_val,
    output rs1_ready, rs1_val, rs1_tag, rs2_ready, rs2_val, rs2_tag, rob_q1_id, rob_q2_id
  );

  modport master (
    output rdy_in, clear_flag, new_reg_id, new_ROB_id, write_reg_id, write_val, write_ROB_id,
    output rs1_reg, rs2_reg, rob_q1_ready, rob_q1_val, rob_q2_ready, rob_q2_val,
    input  rs1_ready, rs1_val, rs1_tag, rs2_ready, rs2_val, rs2_tag, rob_q1_id, rob_q2_id
  );

endinterface

// File: rtl/reg_rename_file_read_port.sv
// rtl/reg_rename_file_read_port.sv - one operand lookup with ROB query mux; optional REG_COMMIT_BYPASS_EN
module reg_read_port
  import reg_rename_file_pkg::*;
#(
  parameter int ROB_SIZE_BIT = reg_rename_file_pkg::ROB_WIDTH_BIT,
  parameter int REG_NUM_BIT  = reg_rename_file_pkg::REG_NUM_BIT
) (
  input  logic [REG_NUM_BIT-1:0]  rd_reg,
  input  logic [2**REG_NUM_BIT-1:0] busy,
  input  logic [ROB_SIZE_BIT-1:0] tag [2**REG_NUM_BIT],
  input  logic [31:0]             val [2**REG_NUM_BIT],
  input  logic [REG_NUM_BIT-1:0]  write_reg_id,
  input  logic [ROB_SIZE_BIT-1:0] write_ROB_id,
  input  logic [31:0]             write_val,
  input  logic                    rob_ready,
  input  logic [31:0]             rob_val,
  output logic                    ready,
  output logic [31:0]             rd_val,
  output logic [ROB_SIZE_BIT-1:0] rd_tag,
  output logic [ROB_SIZE_BIT-1:0] rob_id
);

  logic pending;

`ifndef REG_COMMIT_BYPASS_EN
  // Commit inputs only matter when the commit bypass is built in
  logic unused_commit;
  assign unused_commit = ^{write_reg_id, write_ROB_id, write_val};
`endif

  // Resolve the operand from the file, the ROB query, or leave it as a tag
  always_comb begin
    pending = (rd_reg != '0) && busy[rd_reg];
    ready   = 1'b1;
    rd_val  = val[rd_reg];
    rd_tag  = '0;
    rob_id  = '0;
    if (pending) begin
      rob_id = tag[rd_reg];
      rd_tag = tag[rd_reg];
`ifdef REG_COMMIT_BYPASS_EN
      if ((write_reg_id == rd_reg) && (tag[rd_reg] == write_ROB_id)) begin
        rd_val = write_val;
      end else
`endif
      if (rob_ready) begin
        rd_val = rob_val;
      end else begin
        ready  = 1'b0;
        rd_val = '0;
      end
    end
  end

endmodule

// File: rtl/reg_rename_file.sv
// rtl/reg_rename_file.sv - architectural register file with per-register rename tags
module reg_rename_file
  import reg_rename_file_pkg::*;
#(
  parameter int ROB_SIZE_BIT = reg_rename_file_pkg::ROB_WIDTH_BIT,
  parameter int REG_NUM_BIT  = reg_rename_file_pkg::REG_NUM_BIT
) (
  input logic              clk_in,
  input logic              rst_in,
  reg_rename_file_if.slave bus
);

  localparam int NREG = 2 ** REG_NUM_BIT;

  logic [31:0]             val_q [NREG];
  logic [31:0]             val_d [NREG];
  logic [NREG-1:0]         busy_q;
  logic [NREG-1:0]         busy_d;
  logic [ROB_SIZE_BIT-1:0] tag_q [NREG];
  logic [ROB_SIZE_BIT-1:0] tag_d [NREG];

  // Next state: commit writes value, clear drops all busy, rename overrides commit
  always_comb begin
    val_d  = val_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (bus.rdy_in) begin
      if (bus.write_reg_id != '0) begin
        val_d[bus.write_reg_id] = bus.write_val;
        if ((tag_q[bus.write_reg_id] == bus.write_ROB_id) && (bus.new_reg_id != bus.write_reg_id)) begin
          busy_d[bus.write_reg_id] = 1'b0;
        end
      end
      if (bus.clear_flag) begin
        busy_d = '0;
      end else if (bus.new_reg_id != '0) begin
        busy_d[bus.new_reg_id] = 1'b1;
        tag_d[bus.new_reg_id]  = bus.new_ROB_id;
      end
    end
    val_d[REG_X0]  = '0;
    busy_d[REG_X0] = 1'b0;
    tag_d[REG_X0]  = '0;
  end

  // Register state with asynchronous clear
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q <= '0;
      for (int i = 0; i < NREG; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      val_q  <= val_d;
      tag_q  <= tag_d;
    end
  end

  reg_read_port #(.ROB_SIZE_BIT(ROB_SIZE_BIT), .REG_NUM_BIT(REG_NUM_BIT)) u_port1 (
    .rd_reg       (bus.rs1_reg),
    .busy         (busy_q),
    .tag          (tag_q),
    .val          (val_q),
    .write_reg_id (bus.write_reg_id),
    .write_ROB_id (bus.write_ROB_id),
    .write_val    (bus.write_val),
    .rob_ready    (bus.rob_q1_ready),
    .rob_val      (bus.rob_q1_val),
    .ready        (bus.rs1_ready),
    .rd_val       (bus.rs1_val),
    .rd_tag       (bus.rs1_tag),
    .rob_id       (bus.rob_q1_id)
  );

  reg_read_port #(.ROB_SIZE_BIT(ROB_SIZE_BIT), .REG_NUM_BIT(REG_NUM_BIT)) u_port2 (
    .rd_reg       (bus.rs2_reg),
    .busy         (busy_q),
    .tag          (tag_q),
    .val          (val_q),
    .write_reg_id (bus.write_reg_id),
    .write_ROB_id (bus.write_ROB_id),
    .write_val    (bus.write_val),
    .rob_ready    (bus.rob_q2_ready),
    .rob_val      (bus.rob_q2_val),
    .ready        (bus.rs2_ready),
    .rd_val       (bus.rs2_val),
    .rd_tag       (bus.rs2_tag),
    .rob_id       (bus.rob_q2_id)
  );

endmodule
